// File: rtl/bomb_timer_pkg.sv
// Shared definitions for the bomb game countdown timer: state encoding, BCD constants
// and a nibble clamp helper.
package bomb_timer_pkg;

  typedef logic [1:0] timer_state_t;

  localparam timer_state_t StIdle    = 2'd0;
  localparam timer_state_t StRun     = 2'd1;
  localparam timer_state_t StPaused  = 2'd2;
  localparam timer_state_t StExpired = 2'd3;

  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_NINE) ? BCD_NINE : nibble;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle between the game logic and the BCD countdown timer.
interface bcd_countdown_timer_if #(
  parameter int unsigned NUM_DIGITS = 3
);
  logic [4*NUM_DIGITS-1:0] init_time;
  logic                    load;
  logic                    start_stop;
  logic                    tick;
  logic                    penalty;
  logic [4*NUM_DIGITS-1:0] penalty_time;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    running;
  logic                    expired;
  logic                    expired_pulse;

  modport master (
    output init_time, load, start_stop, tick, penalty, penalty_time,
    input  digits, running, expired, expired_pulse
  );

  modport slave (
    input  init_time, load, start_stop, tick, penalty, penalty_time,
    output digits, running, expired, expired_pulse
  );
endinterface

// File: rtl/bcd_sub_sat.sv
// Combinational N-digit BCD subtractor with a per-nibble borrow chain; a final borrow
// saturates the difference to zero and raises underflow.
module bcd_sub_sat #(
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic [4*NUM_DIGITS-1:0] minuend,
  input  logic [4*NUM_DIGITS-1:0] subtrahend,
  output logic [4*NUM_DIGITS-1:0] difference,
  output logic                    underflow
);

  logic [4*NUM_DIGITS-1:0] raw;
  logic [4:0]              nib_diff;
  logic                    borrow;

  always_comb begin
    raw      = '0;
    nib_diff = '0;
    borrow   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_diff = {1'b0, minuend[4*i +: 4]} - {1'b0, subtrahend[4*i +: 4]} - {4'd0, borrow};
      // Negative nibble: wrap by adding ten (mod 16) and borrow from the next digit.
      if (nib_diff[4]) begin
        raw[4*i +: 4] = nib_diff[3:0] + 4'd10;
        borrow        = 1'b1;
      end else begin
        raw[4*i +: 4] = nib_diff[3:0];
        borrow        = 1'b0;
      end
    end
    underflow  = borrow;
    difference = borrow ? '0 : raw;
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with pause/resume, saturating penalty subtraction,
// mid-run reload and registered expiry level/strobe.
module bcd_countdown_timer
  import bomb_timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 3,
  parameter bit          CLAMP_INVALID = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  bcd_countdown_timer_if.slave bus
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  timer_state_t state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] init_c, pen_c, sub_b, diff;
  logic         underflow, hit_zero;
  logic         running_q, expired_q, expired_pulse_q;

  always_comb begin
    init_c = '0;
    pen_c  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      init_c[4*i +: 4] = CLAMP_INVALID ? bcd_clamp(bus.init_time[4*i +: 4])
                                       : bus.init_time[4*i +: 4];
      pen_c[4*i +: 4]  = CLAMP_INVALID ? bcd_clamp(bus.penalty_time[4*i +: 4])
                                       : bus.penalty_time[4*i +: 4];
    end
  end

  // One subtractor serves both the tick (minus one) and the penalty.
  assign sub_b = bus.penalty ? pen_c : {{(W-1){1'b0}}, 1'b1};

  bcd_sub_sat #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_sub (
    .minuend    (count_q),
    .subtrahend (sub_b),
    .difference (diff),
    .underflow  (underflow)
  );

  assign hit_zero = underflow || (diff == '0);

  // Raw pulse priority: a higher pulse drops every lower one even if it has no effect.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.load) begin
      count_d = init_c;
      state_d = StIdle;
    end else if (bus.penalty) begin
      if (state_q == StRun || state_q == StPaused) begin
        count_d = diff;
        if (hit_zero) state_d = StExpired;
      end
    end else if (bus.start_stop) begin
      case (state_q)
        StIdle:   state_d = (count_q != '0) ? StRun : StExpired;
        StRun:    state_d = StPaused;
        StPaused: state_d = StRun;
        default:  state_d = state_q;
      endcase
    end else if (bus.tick && state_q == StRun) begin
      count_d = diff;
      if (hit_zero) state_d = StExpired;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= StIdle;
      count_q         <= '0;
      running_q       <= 1'b0;
      expired_q       <= 1'b0;
      expired_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      running_q       <= (state_d == StRun);
      expired_q       <= (state_d == StExpired);
      expired_pulse_q <= (state_d == StExpired) && (state_q != StExpired);
    end
  end

  assign bus.digits        = count_q;
  assign bus.running       = running_q;
  assign bus.expired       = expired_q;
  assign bus.expired_pulse = expired_pulse_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed vector table plus randomized run against a decimal-arithmetic reference model.
module tb_bcd_countdown_timer;

  localparam int unsigned ND = 3;
  localparam int unsigned W  = 4 * ND;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.NUM_DIGITS(ND)) bus ();

  bcd_countdown_timer #(
    .NUM_DIGITS    (ND),
    .CLAMP_INVALID (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic         rst_n;
    logic         load;
    logic         ss;
    logic         tick;
    logic         pen;
    logic [W-1:0] init;
    logic [W-1:0] ptime;
    logic [W-1:0] exp_digits;
    logic         exp_run;
    logic         exp_expired;
    logic         exp_pulse;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain decimal integer count and a named phase.
  int   m_cnt;
  int   m_phase;  // 0 idle, 1 run, 2 paused, 3 expired
  logic m_pulse;

  function automatic int bcd_value(input logic [W-1:0] v);
    int acc = 0;
    int scale = 1;
    for (int i = 0; i < ND; i++) begin
      int nib = int'(v[4*i +: 4]);
      if (nib > 9) nib = 9;
      acc += nib * scale;
      scale *= 10;
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int val);
    logic [W-1:0] r = '0;
    int v = val;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input logic rst_n, input logic ld, input logic ss, input logic tk,
                            input logic pn, input logic [W-1:0] init, input logic [W-1:0] pt);
    bit was_exp = (m_phase == 3);
    if (!rst_n) begin
      m_cnt = 0;
      m_phase = 0;
    end else if (ld) begin
      m_cnt = bcd_value(init);
      m_phase = 0;
    end else if (pn) begin
      if (m_phase == 1 || m_phase == 2) begin
        m_cnt = m_cnt - bcd_value(pt);
        if (m_cnt <= 0) begin
          m_cnt = 0;
          m_phase = 3;
        end
      end
    end else if (ss) begin
      if (m_phase == 0) m_phase = (m_cnt != 0) ? 1 : 3;
      else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2) m_phase = 1;
    end else if (tk && m_phase == 1) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_phase = 3;
    end
    m_pulse = rst_n && (m_phase == 3) && !was_exp;
  endtask

  task automatic check1(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply(input logic rst_n, input logic ld, input logic ss, input logic tk,
                       input logic pn, input logic [W-1:0] init, input logic [W-1:0] pt);
    @(negedge clk);
    reset            = rst_n;
    bus.load         = ld;
    bus.start_stop   = ss;
    bus.tick         = tk;
    bus.penalty      = pn;
    bus.init_time    = init;
    bus.penalty_time = pt;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ld, input logic ss, input logic tk, input logic pn,
                     input logic [W-1:0] init, input logic [W-1:0] pt, input logic [W-1:0] ed,
                     input logic er, input logic ee, input logic ep, input logic rst_n = 1'b1);
    vec_t v;
    v.rst_n = rst_n; v.load = ld; v.ss = ss; v.tick = tk; v.pen = pn;
    v.init = init; v.ptime = pt; v.exp_digits = ed;
    v.exp_run = er; v.exp_expired = ee; v.exp_pulse = ep;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    bus.load = 1'b0; bus.start_stop = 1'b0; bus.tick = 1'b0; bus.penalty = 1'b0;
    bus.init_time = '0; bus.penalty_time = '0;

    //   ld ss tk pn init     ptime    digits   run exp pls
    add(0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 1'b0);  // reset
    add(1, 0, 0, 0, 12'h105, 12'h000, 12'h105, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h105, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h104, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h103, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h102, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h101, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h100, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h099, 1, 0, 0);
    // 001 -> 000 expiry, then ticks and start_stop ignored
    add(1, 0, 0, 0, 12'h001, 12'h000, 12'h001, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h001, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h000, 0, 1, 1);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h000, 0, 1, 0);
    add(0, 1, 1, 0, 12'h000, 12'h000, 12'h000, 0, 1, 0);
    // penalty larger than count saturates; same-cycle tick dropped
    add(1, 0, 0, 0, 12'h025, 12'h000, 12'h025, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h025, 1, 0, 0);
    add(0, 0, 1, 1, 12'h000, 12'h030, 12'h000, 0, 1, 1);
    add(0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 1, 0);
    // pause, penalty while paused, resume
    add(1, 0, 0, 0, 12'h050, 12'h000, 12'h050, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h050, 1, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h050, 0, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h050, 0, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h050, 0, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h050, 0, 0, 0);
    add(0, 0, 0, 1, 12'h000, 12'h010, 12'h040, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h040, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h039, 1, 0, 0);
    // mid-run reload with invalid digit clamped; tick dropped
    add(1, 0, 0, 0, 12'h200, 12'h000, 12'h200, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h200, 1, 0, 0);
    add(1, 0, 1, 0, 12'h0A7, 12'h000, 12'h097, 0, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h097, 0, 0, 0);
    // borrow across a zero digit, then exact penalty to zero while paused
    add(1, 0, 0, 0, 12'h010, 12'h000, 12'h010, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h010, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h009, 1, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h009, 0, 0, 0);
    add(0, 0, 0, 1, 12'h000, 12'h009, 12'h000, 0, 1, 1);
    // reset mid-run, then start_stop on zero count expires
    add(1, 0, 0, 0, 12'h123, 12'h000, 12'h123, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h123, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 1'b0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h000, 0, 1, 1);
    add(0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 1, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].load, vecs[i].ss, vecs[i].tick, vecs[i].pen,
            vecs[i].init, vecs[i].ptime);
      check1($sformatf("vec%0d digits", i), bus.digits, vecs[i].exp_digits);
      check1($sformatf("vec%0d running", i), W'(bus.running), W'(vecs[i].exp_run));
      check1($sformatf("vec%0d expired", i), W'(bus.expired), W'(vecs[i].exp_expired));
      check1($sformatf("vec%0d pulse", i), W'(bus.expired_pulse), W'(vecs[i].exp_pulse));
    end

    // Randomized phase against the model, starting from a reset.
    m_cnt = 0; m_phase = 0; m_pulse = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 3000; c++) begin
      logic rn, ld, ss, tk, pn;
      logic [W-1:0] init, pt;
      rn = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 39) == 0);
      ss = ($urandom_range(0, 11) == 0);
      tk = ($urandom_range(0, 2) == 0);
      pn = ($urandom_range(0, 19) == 0);
      init = W'($urandom);
      if ($urandom_range(0, 3) != 0) init = to_bcd(int'($urandom_range(0, 60)));
      pt = to_bcd(int'($urandom_range(0, 25)));
      if ($urandom_range(0, 9) == 0) pt = W'($urandom);
      apply(rn, ld, ss, tk, pn, init, pt);
      model_step(rn, ld, ss, tk, pn, init, pt);
      check1("rand digits", bus.digits, to_bcd(m_cnt));
      check1("rand running", W'(bus.running), W'(m_phase == 1));
      check1("rand expired", W'(bus.expired), W'(m_phase == 3));
      check1("rand pulse", W'(bus.expired_pulse), W'(m_pulse));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
